// File: rtl/seq_divider16.sv
// seq_divider16 -- 16-bit sequential restoring divider.
//
// The divider works one quotient bit per clock, starting at the MSB. A start
// is accepted when load=1 in IDLE or DONE. The result is presented, with
// done=1, 16 cycles after the accepting edge. In the signed build the result
// appears 17 cycles after that edge. A zero divisor finishes one cycle after
// the accepting edge. The result is held until the next accepted start or
// reset.
//
// Build option:
//   DIV_SIGNED_EN  When defined, operands are two's complement. The quotient
//                  truncates toward zero and the remainder takes the sign of
//                  the dividend. One extra cycle is used for sign correction.
//                  The ports are unchanged.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   load         start request
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   quotient     registered quotient, valid while done=1
//   remainder    registered remainder, valid while done=1
//   done         result valid; held until the next accepted start or reset
//   busy         high while the divider is iterating (RUN)
//   div_by_zero  the last accepted operation had divisor==0; valid with done
module seq_divider16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef DIV_SIGNED_EN
  // 16 shift-subtract steps plus one sign-correction cycle.
  localparam logic [4:0] LOAD_COUNT = 5'd17;
`else
  localparam logic [4:0] LOAD_COUNT = 5'd16;
`endif

  state_t      state;
  logic [4:0]  count;
  logic [15:0] dq;        // dividend bits shift out the top; quotient bits shift in the bottom
  logic [15:0] part;      // partial remainder; it is always < divisor, so 16 bits are enough
  logic [15:0] dvs;       // captured divisor (its magnitude in the signed build)
  logic [15:0] orig;      // dividend as presented; used as the remainder for a zero divisor
  logic        zero;      // captured divisor was zero

  // One restoring step. The 17-bit shifted partial is compared with the divisor.
  logic [16:0] part_shift;
  logic        take;
  logic [15:0] part_diff;
  logic [15:0] part_step;
  logic [15:0] dq_step;

  always_comb begin
    part_shift = {part, dq[15]};
    take       = (part_shift >= {1'b0, dvs});
    // The subtraction is only used when take=1. In that case the result fits
    // in 16 bits, so it is done modulo 2^16.
    part_diff  = part_shift[15:0] - dvs;
    part_step  = take ? part_diff : part_shift[15:0];
    dq_step    = {dq[14:0], take};
  end

  // Operand magnitudes to capture. The unsigned build uses them unchanged.
  logic [15:0] dd_cap;
  logic [15:0] dv_cap;

`ifdef DIV_SIGNED_EN
  logic q_neg;   // quotient must be negated (operand signs differ)
  logic r_neg;   // remainder must be negated (dividend negative)

  // Two's-complement magnitude. 16'h8000 maps to 16'h8000, which is correct when read unsigned.
  always_comb begin
    dd_cap = dividend[15] ? (~dividend + 16'd1) : dividend;
    dv_cap = divisor[15]  ? (~divisor  + 16'd1) : divisor;
  end
`else
  always_comb begin
    dd_cap = dividend;
    dv_cap = divisor;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 5'd0;
      dq          <= 16'd0;
      part        <= 16'd0;
      dvs         <= 16'd0;
      orig        <= 16'd0;
      zero        <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 16'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            dq          <= dd_cap;
            dvs         <= dv_cap;
            orig        <= dividend;
            part        <= 16'd0;
            zero        <= (divisor == 16'd0);
            count       <= LOAD_COUNT;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
`ifdef DIV_SIGNED_EN
            q_neg       <= dividend[15] ^ divisor[15];
            r_neg       <= dividend[15];
`endif
          end
        end

        RUN: begin
          if (zero) begin
            // A zero divisor has a fixed result and finishes on the first RUN edge.
            quotient    <= 16'hFFFF;
            remainder   <= orig;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            count       <= 5'd0;
            state       <= DONE;
`ifdef DIV_SIGNED_EN
          end else if (count == 5'd1) begin
            // Extra cycle: apply the signs to the unsigned quotient and remainder.
            quotient    <= q_neg ? (~dq + 16'd1) : dq;
            remainder   <= r_neg ? (~part + 16'd1) : part;
            done        <= 1'b1;
            busy        <= 1'b0;
            count       <= 5'd0;
            state       <= DONE;
`endif
          end else begin
            dq    <= dq_step;
            part  <= part_step;
            count <= count - 5'd1;
`ifndef DIV_SIGNED_EN
            if (count == 5'd1) begin
              quotient  <= dq_step;
              remainder <= part_step;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
`endif
          end
          // load is ignored here: operands and progress stay as they are.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
